riscv_dmem_responder: RTL

Data-memory responder for the pipelined RV32I core. It sits on the core's M-stage memory port and serves it with a word-organised RAM that supports byte-lane stores and RISC-V load extraction by func3. It flags misaligned stores and, optionally, provides a small MMIO window holding a tohost register and a cycle counter. Read data returns in the same cycle, which matches the core capturing read data into its M/W register at the end of M.

---
 rtl/riscv_dmem_responder_pkg.sv | 35 +++
 rtl/riscv_dmem_load_ext.sv | 45 ++++
 rtl/riscv_dmem_responder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/riscv_dmem_responder_pkg.sv
// Shared constants for the RV32I data-memory responder.
// XLEN, load/store funct3 encodings and store-size classification.
package riscv_dmem_responder_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] FUNCT3_LOAD_LB  = 3'b000;
   localparam logic [2:0] FUNCT3_LOAD_LH  = 3'b001;
   localparam logic [2:0] FUNCT3_LOAD_LW  = 3'b010;
   localparam logic [2:0] FUNCT3_LOAD_LBU = 3'b100;
   localparam logic [2:0] FUNCT3_LOAD_LHU = 3'b101;

   localparam logic [2:0] FUNCT3_STORE_SB = 3'b000;
   localparam logic [2:0] FUNCT3_STORE_SH = 3'b001;
   localparam logic [2:0] FUNCT3_STORE_SW = 3'b010;

   localparam logic [3:0] BSEL_BYTE = 4'b0001;
   localparam logic [3:0] BSEL_HALF = 4'b0011;

   typedef enum logic [1:0] {
      SZ_BYTE,
      SZ_HALF,
      SZ_WORD
   } st_size_e;

   // Unrecognised masks fall through to word.
   function automatic st_size_e st_size(input logic [3:0] sel);
      st_size_e sz;
      sz = SZ_WORD;
      if (sel == BSEL_BYTE) sz = SZ_BYTE;
      else if (sel == BSEL_HALF) sz = SZ_HALF;
      return sz;
   endfunction

endpackage

// File: rtl/riscv_dmem_load_ext.sv
// Load formatting: offset shift, func3 sign/zero extension,
// and zero result for misaligned half/word loads.
module riscv_dmem_load_ext
   import riscv_dmem_responder_pkg::*;
(
   input  logic [XLEN-1:0] word_i,
   input  logic [1:0]      off_i,
   input  logic [2:0]      func3_i,
   output logic [XLEN-1:0] data_o
);

   logic [XLEN-1:0] shifted;
   logic            misal;

   always_comb begin
      shifted = word_i >> {off_i, 3'b000};
      misal   = 1'b0;
      data_o  = shifted;
      unique case (func3_i)
         FUNCT3_LOAD_LB: begin
            data_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         end
         FUNCT3_LOAD_LH: begin
            data_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            misal  = off_i[0];
         end
         FUNCT3_LOAD_LW: begin
            data_o = shifted;
            misal  = (off_i != 2'b00);
         end
         FUNCT3_LOAD_LBU: begin
            data_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
         end
         FUNCT3_LOAD_LHU: begin
            data_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
            misal  = off_i[0];
         end
         default: begin
            data_o = shifted;
         end
      endcase
      if (misal) data_o = '0;
   end

endmodule

// File: rtl/riscv_dmem_responder.sv
// M-stage data memory: byte-lane RAM, misaligned-store errors,
// optional tohost/cycle MMIO window (RISCV_DMEM_MMIO_EN).
module riscv_dmem_responder
   import riscv_dmem_responder_pkg::*;
#(
   parameter int              DEPTH     = 1024,
   parameter logic [XLEN-1:0] MMIO_BASE = 32'hFFFF_0000
) (
   input  logic            i_clk,
   input  logic            i_rstn,
   input  logic [XLEN-1:0] i_dmem_addr,
   input  logic [XLEN-1:0] i_dmem_wr_data,
   input  logic            i_dmem_wr_en,
   input  logic [3:0]      i_dmem_byte_sel,
   input  logic [2:0]      i_dmem_func3,
   output logic [XLEN-1:0] o_dmem_rd_data,
   output logic            o_dmem_misalign,
   output logic            o_dmem_err_sticky,
   output logic [7:0]      o_dmem_err_cnt,
   output logic [XLEN-1:0] o_dmem_tohost,
   output logic            o_dmem_tohost_valid
);

   localparam int AW = $clog2(DEPTH);

   logic [XLEN-1:0] mem_q [DEPTH];

   logic [AW-1:0]   idx;
   logic [1:0]      off;
   st_size_e        sz;
   logic            misalign;
   logic            mmio_hit;
   logic            ram_we;
   logic [3:0]      lane_mask;
   logic [XLEN-1:0] wr_shift;
   logic [XLEN-1:0] rd_word;

   logic            err_sticky_q, err_sticky_d;
   logic [7:0]      err_cnt_q, err_cnt_d;

   assign idx       = i_dmem_addr[AW+1:2];
   assign off       = i_dmem_addr[1:0];
   assign sz        = st_size(i_dmem_byte_sel);
   assign lane_mask = i_dmem_byte_sel << off;
   assign wr_shift  = i_dmem_wr_data << {off, 3'b000};

   always_comb begin
      misalign = 1'b0;
      if (i_dmem_wr_en) begin
         misalign = (sz == SZ_HALF && off[0]) ||
                    (sz == SZ_WORD && off != 2'b00);
      end
   end

   // Stores during reset are dropped; RAM itself is never reset.
   assign ram_we = i_dmem_wr_en && !misalign && !mmio_hit && i_rstn;

   always_ff @(posedge i_clk) begin
      if (ram_we) begin
         for (int b = 0; b < 4; b++) begin
            if (lane_mask[b]) mem_q[idx][8*b +: 8] <= wr_shift[8*b +: 8];
         end
      end
   end

   always_comb begin
      err_sticky_d = err_sticky_q | misalign;
      err_cnt_d    = err_cnt_q;
      if (misalign && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         err_sticky_q <= 1'b0;
         err_cnt_q    <= 8'd0;
      end else begin
         err_sticky_q <= err_sticky_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

`ifdef RISCV_DMEM_MMIO_EN
   localparam logic [XLEN-1:0] MMIO_CYC = MMIO_BASE + 32'd4;

   logic            hit_th, hit_cyc, th_we;
   logic [XLEN-1:0] tohost_q, tohost_d;
   logic            tohost_valid_q, tohost_valid_d;
   logic [31:0]     cycle_q, cycle_d;

   // Word-granular match so sub-word loads see the MMIO word.
   assign hit_th   = i_dmem_addr[XLEN-1:2] == MMIO_BASE[XLEN-1:2];
   assign hit_cyc  = i_dmem_addr[XLEN-1:2] == MMIO_CYC[XLEN-1:2];
   assign mmio_hit = hit_th || hit_cyc;
   assign th_we    = i_dmem_wr_en && hit_th && sz == SZ_WORD && !misalign;

   always_comb begin
      tohost_d       = tohost_q;
      tohost_valid_d = th_we;
      cycle_d        = cycle_q + 32'd1;
      if (th_we) tohost_d = i_dmem_wr_data;
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         tohost_q       <= '0;
         tohost_valid_q <= 1'b0;
         cycle_q        <= 32'd0;
      end else begin
         tohost_q       <= tohost_d;
         tohost_valid_q <= tohost_valid_d;
         cycle_q        <= cycle_d;
      end
   end

   always_comb begin
      rd_word = mem_q[idx];
      if (hit_th) rd_word = tohost_q;
      else if (hit_cyc) rd_word = cycle_q;
   end

   assign o_dmem_tohost       = tohost_q;
   assign o_dmem_tohost_valid = tohost_valid_q;
`else
   logic unused_mmio;

   assign mmio_hit            = 1'b0;
   assign rd_word             = mem_q[idx];
   assign o_dmem_tohost       = '0;
   assign o_dmem_tohost_valid = 1'b0;
   assign unused_mmio         = ^{i_dmem_addr[XLEN-1:AW+2], MMIO_BASE};
`endif

   riscv_dmem_load_ext u_load_ext (
      .word_i  (rd_word),
      .off_i   (off),
      .func3_i (i_dmem_func3),
      .data_o  (o_dmem_rd_data)
   );

   assign o_dmem_misalign   = misalign;
   assign o_dmem_err_sticky = err_sticky_q;
   assign o_dmem_err_cnt    = err_cnt_q;

endmodule
